// File: rtl/wb_interconnect.sv
// wb_interconnect: single-master, 3-slave Wishbone address decoder and sequencer.
// Slave map: 0 = bootrom b0000000-b0007fff, 1 = RAM b0008000-b000ffff,
// 2 = UART c0000000-c000ffff. Anything else ends in a one-cycle bus error.
// Define WB_IC_TIMEOUT_EN to abort hung slaves after TIMEOUT REQ/WAIT cycles.
module wb_interconnect #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_m_addr,
  input  logic [31:0] i_m_data,
  input  logic        i_m_we,
  input  logic [1:0]  i_m_width,
  input  logic        i_m_cyc,
  input  logic        i_m_stb,
  output logic        o_m_stl,
  output logic        o_m_ack,
  output logic        o_m_err,
  output logic [31:0] o_m_data,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic        o_s_we,
  output logic [1:0]  o_s_width,
  output logic        o_s_cyc,
  output logic [2:0]  o_s_stb,
  input  logic [2:0]  i_s_stl,
  input  logic [2:0]  i_s_ack,
  input  logic [95:0] i_s_data
);
  localparam int NUM_SLV = 3;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

  state_t              state;
  logic [NUM_SLV-1:0]  sel_oh;
  logic [NUM_SLV-1:0]  dec_oh;
  logic                acc;
  logic                sel_ack;
  logic [31:0]         rd_data;
  logic                tmo_hit;

  // decode master address into a one-hot slave select (zero = unmapped)
  always_comb begin
    dec_oh = '0;
    if (i_m_addr[31:16] == 16'hb000)      dec_oh = i_m_addr[15] ? 3'b010 : 3'b001;
    else if (i_m_addr[31:16] == 16'hc000) dec_oh = 3'b100;
  end

  // only the selected slave's stall/ack/data are ever looked at
  assign acc     = |(sel_oh & ~i_s_stl);
  assign sel_ack = |(sel_oh & i_s_ack);

  // AND-OR read data mux over the one-hot select
  always_comb begin
    rd_data = '0;
    for (int n = 0; n < NUM_SLV; n++)
      if (sel_oh[n]) rd_data = rd_data | i_s_data[32*n +: 32];
  end

  // bus handshakes are pure decodes of the state register
  assign o_m_stl = (state != S_IDLE);
  assign o_s_cyc = (state == S_REQ) || (state == S_WAIT);
  assign o_s_stb = (state == S_REQ) ? sel_oh : '0;
  assign o_m_ack = (state == S_RESP);
  assign o_m_err = (state == S_ERR);

`ifdef WB_IC_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;

  // expiry is judged on the cycle that would bring the count to TIMEOUT
  assign tmo_hit = (tmo_cnt >= TMO_LAST);

  // REQ/WAIT cycle counter; parked at zero in IDLE so it restarts on entry to REQ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           tmo_cnt <= '0;
    else if (state == S_IDLE)             tmo_cnt <= '0;
    else if (o_s_cyc && tmo_cnt != 8'hff) tmo_cnt <= tmo_cnt + 8'd1;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT;
`endif

  // transaction sequencer: latch request, strobe slave, wait for ack, respond
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sel_oh    <= '0;
      o_s_addr  <= '0;
      o_s_data  <= '0;
      o_s_we    <= 1'b0;
      o_s_width <= '0;
      o_m_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_m_cyc && i_m_stb) begin
          o_s_addr  <= i_m_addr;
          o_s_data  <= i_m_data;
          o_s_we    <= i_m_we;
          o_s_width <= i_m_width;
          sel_oh    <= dec_oh;
          state     <= (|dec_oh) ? S_REQ : S_ERR;
        end
        S_REQ: begin
          // a dropped cycle beats everything, including a timeout
          if (!i_m_cyc)            state <= S_IDLE;
          else if (acc && sel_ack) begin
            o_m_data <= rd_data;
            state    <= S_RESP;
          end
          else if (tmo_hit)        state <= S_ERR;
          else if (acc)            state <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_m_cyc)            state <= S_IDLE;
          else if (sel_ack) begin
            o_m_data <= rd_data;
            state    <= S_RESP;
          end
          else if (tmo_hit)        state <= S_ERR;
        end
        S_RESP:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Bench for wb_interconnect: reset values, a directed vector table, random
// transactions against a range-based reference, aborts, reset and hung slaves.
module tb_wb_interconnect;
`ifdef WB_IC_TIMEOUT_EN
  localparam int TMO  = 4;
  localparam int MAXW = 1;   // keeps every legal transaction under the timeout
`else
  localparam int TMO  = 255;
  localparam int MAXW = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
  logic [1:0]  m_width = '0;
  logic        o_m_stl, o_m_ack, o_m_err;
  logic [31:0] o_m_data, o_s_addr, o_s_data;
  logic        o_s_we, o_s_cyc;
  logic [1:0]  o_s_width;
  logic [2:0]  o_s_stb;
  logic [2:0]  s_stl = '0, s_ack = '0;
  logic [95:0] s_data = '0;

  int errors = 0;
  int checks = 0;

  wb_interconnect #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_m_addr(m_addr), .i_m_data(m_data), .i_m_we(m_we), .i_m_width(m_width),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb),
    .o_m_stl(o_m_stl), .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_data(o_m_data),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_we(o_s_we), .o_s_width(o_s_width),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
    .i_s_stl(s_stl), .i_s_ack(s_ack), .i_s_data(s_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic [1:0]  width;
    int          stl;      // REQ cycles the target holds stall
    int          d;        // ack delay after acceptance
    logic [2:0]  exp_oh;   // expected strobe pattern, 0 = unmapped
    int          exp_done; // cycle of o_m_ack / o_m_err
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: address ranges straight from the memory map
  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    if (a >= 32'hb000_0000 && a <= 32'hb000_7fff) return 3'b001;
    if (a >= 32'hb000_8000 && a <= 32'hb000_ffff) return 3'b010;
    if (a >= 32'hc000_0000 && a <= 32'hc000_ffff) return 3'b100;
    return 3'b000;
  endfunction

  // accept at cycle 0, strobe from cycle 1, accepted at 1+stl, ack d later,
  // response one cycle after the ack; unmapped errors at cycle 1
  function automatic int ref_done(input logic [2:0] oh, input int stl, input int d);
    return (oh != 0) ? 2 + stl + d : 1;
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] wd, input logic we);
    m_addr = a; m_data = wd; m_we = we; m_width = 2'd2;
    m_cyc = 1'b1; m_stb = 1'b1;
    s_stl = '0; s_ack = '0; s_data = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int tgt, ack_n, err_n, ack_c, err_c, stb_n, stb_bad, last;
    logic [31:0] data_before, data_at_ack;
    logic stl_at_err;
    tgt = (v.exp_oh == 3'b010) ? 1 : (v.exp_oh == 3'b100) ? 2 : 0;
    ack_n = 0; err_n = 0; ack_c = -1; err_c = -1; stb_n = 0; stb_bad = 0;
    data_before = o_m_data; data_at_ack = '0; stl_at_err = 1'b0;
    last = v.exp_done + 2;
    for (int t = 0; t <= last; t++) begin
      m_cyc = (t <= v.exp_done);
      m_stb = (t == 0);
      if (t == 0) begin
        m_addr = v.addr; m_data = v.wdata; m_we = v.we; m_width = v.width;
      end
      s_stl  = 3'($urandom);
      s_ack  = 3'($urandom);
      s_data = {$urandom, $urandom, $urandom};
      if (v.exp_oh != 0) begin
        s_stl[tgt] = (t >= 1 && t <= v.stl);
        // real ack plus a stray one in the response cycle, which must be ignored
        s_ack[tgt] = (t == 1 + v.stl + v.d) || (t == v.exp_done);
        if (t == 1 + v.stl + v.d) s_data[32*tgt +: 32] = v.rdata;
      end
      if (o_m_ack) begin ack_n++; ack_c = t; data_at_ack = o_m_data; end
      if (o_m_err) begin err_n++; err_c = t; stl_at_err = o_m_stl; end
      if (o_s_stb != 0) begin
        if (o_s_stb == v.exp_oh) stb_n++;
        else stb_bad++;
      end
      if (t == 1 && v.exp_oh != 0) begin
        chk({tag, " s_addr"},  o_s_addr, v.addr);
        chk({tag, " s_data"},  o_s_data, v.wdata);
        chk({tag, " s_we"},    32'(o_s_we), 32'(v.we));
        chk({tag, " s_width"}, 32'(o_s_width), 32'(v.width));
        chk({tag, " s_cyc"},   32'(o_s_cyc), 32'd1);
      end
      tick();
    end
    chk({tag, " stb cycles"}, stb_n, (v.exp_oh != 0) ? v.stl + 1 : 0);
    chk({tag, " stb wrong"},  stb_bad, 0);
    if (v.exp_oh != 0) begin
      chk({tag, " ack count"}, ack_n, 1);
      chk({tag, " ack cycle"}, ack_c, v.exp_done);
      chk({tag, " ack data"},  data_at_ack, v.rdata);
      chk({tag, " err count"}, err_n, 0);
    end else begin
      chk({tag, " err count"},  err_n, 1);
      chk({tag, " err cycle"},  err_c, 1);
      chk({tag, " stl at err"}, 32'(stl_at_err), 32'd1);
      chk({tag, " ack count"},  ack_n, 0);
      chk({tag, " data kept"},  o_m_data, data_before);
    end
    chk({tag, " idle stl"}, 32'(o_m_stl), 32'd0);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    int n_bad, n_low, err_c, ack_n;
    logic cyc_at_err;

    tbl[0] = '{addr:32'hb000_0010, wdata:32'h0, rdata:32'h1234_5678, we:1'b0, width:2'd2, stl:0, d:1, exp_oh:3'b001, exp_done:3};
    tbl[1] = '{addr:32'hb000_8004, wdata:32'hdead_beef, rdata:32'h0bad_f00d, we:1'b1, width:2'd2, stl:2, d:0, exp_oh:3'b010, exp_done:4};
    tbl[2] = '{addr:32'ha000_0000, wdata:32'h1, rdata:32'h0, we:1'b0, width:2'd0, stl:0, d:0, exp_oh:3'b000, exp_done:1};
    tbl[3] = '{addr:32'hc000_0001, wdata:32'h0, rdata:32'h5a5a_0001, we:1'b0, width:2'd0, stl:0, d:2, exp_oh:3'b100, exp_done:4};
    tbl[4] = '{addr:32'hb000_7ffc, wdata:32'h0, rdata:32'hcafe_0000, we:1'b0, width:2'd2, stl:0, d:0, exp_oh:3'b001, exp_done:2};
    tbl[5] = '{addr:32'hb000_8000, wdata:32'h7777_8888, rdata:32'h1111_2222, we:1'b1, width:2'd1, stl:1, d:1, exp_oh:3'b010, exp_done:4};
    tbl[6] = '{addr:32'hc000_fffc, wdata:32'h0, rdata:32'h8000_0001, we:1'b0, width:2'd2, stl:0, d:0, exp_oh:3'b100, exp_done:2};
    tbl[7] = '{addr:32'hb001_0000, wdata:32'h0, rdata:32'h0, we:1'b0, width:2'd2, stl:0, d:0, exp_oh:3'b000, exp_done:1};
    tbl[8] = '{addr:32'hafff_ffff, wdata:32'h0, rdata:32'h0, we:1'b1, width:2'd2, stl:0, d:0, exp_oh:3'b000, exp_done:1};
    tbl[9] = '{addr:32'hc001_0000, wdata:32'h0, rdata:32'h0, we:1'b0, width:2'd2, stl:0, d:0, exp_oh:3'b000, exp_done:1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst m_stl",   32'(o_m_stl), 32'd0);
    chk("rst m_ack",   32'(o_m_ack), 32'd0);
    chk("rst m_err",   32'(o_m_err), 32'd0);
    chk("rst m_data",  o_m_data, 32'd0);
    chk("rst s_addr",  o_s_addr, 32'd0);
    chk("rst s_data",  o_s_data, 32'd0);
    chk("rst s_we",    32'(o_s_we), 32'd0);
    chk("rst s_width", 32'(o_s_width), 32'd0);
    chk("rst s_cyc",   32'(o_s_cyc), 32'd0);
    chk("rst s_stb",   32'(o_s_stb), 32'd0);
    reset = 1'b1;
    tick();

    // directed table
    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // random transactions against the range reference
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rv.addr = 32'hb000_0000 + $urandom_range(0, 32'h7fff);
        1:       rv.addr = 32'hb000_8000 + $urandom_range(0, 32'h7fff);
        2:       rv.addr = 32'hc000_0000 + $urandom_range(0, 32'hffff);
        default: rv.addr = $urandom;
      endcase
      rv.wdata = $urandom; rv.rdata = $urandom;
      rv.we = 1'($urandom); rv.width = 2'($urandom);
      rv.stl = $urandom_range(0, MAXW);
      rv.d   = $urandom_range(0, MAXW);
      rv.exp_oh   = ref_sel(rv.addr);
      rv.exp_done = ref_done(rv.exp_oh, rv.stl, rv.d);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // master drops cycle in WAIT; late ack must not surface
    start(32'hb000_8010, 32'h0, 1'b0);
    tick();                                   // cycle 1: REQ
    m_stb = 1'b0;
    chk("abw stb", 32'(o_s_stb), 32'b010);
    tick();                                   // cycle 2: WAIT
    chk("abw wait cyc", 32'(o_s_cyc), 32'd1);
    chk("abw wait stb", 32'(o_s_stb), 32'd0);
    m_cyc = 1'b0;
    tick();                                   // cycle 3: IDLE
    chk("abw cyc", 32'(o_s_cyc), 32'd0);
    chk("abw stl", 32'(o_m_stl), 32'd0);
    chk("abw ack/err", {o_m_ack, o_m_err}, 32'd0);
    s_ack = 3'b010; s_data[63:32] = 32'hffff_ffff;
    tick();
    s_ack = '0;
    tick();
    chk("abw late ack", {o_m_ack, o_m_err}, 32'd0);
    run_vec(tbl[0], "after abw");

    // master drops cycle while the slave stalls in REQ
    start(32'hc000_0000, 32'h0, 1'b0);
    s_stl = 3'b100;
    tick();                                   // cycle 1: REQ, stalled
    m_stb = 1'b0;
    chk("abr stb", 32'(o_s_stb), 32'b100);
    m_cyc = 1'b0;
    tick();
    chk("abr cyc/stb", {o_s_cyc, o_s_stb}, 32'd0);
    chk("abr stl/ack/err", {o_m_stl, o_m_ack, o_m_err}, 32'd0);
    s_stl = '0;

    // async reset mid-WAIT clears everything
    start(32'hb000_0020, 32'h1357_9bdf, 1'b1);
    tick();
    m_stb = 1'b0;
    tick();                                   // cycle 2: WAIT
    #2 reset = 1'b0;
    #1;
    chk("rwait ctrl", {o_m_stl, o_m_ack, o_m_err, o_s_cyc, o_s_stb}, 32'd0);
    chk("rwait m_data", o_m_data, 32'd0);
    chk("rwait s_addr", o_s_addr, 32'd0);
    chk("rwait s_data", o_s_data, 32'd0);
    chk("rwait s_we/width", {o_s_we, o_s_width}, 32'd0);
    m_cyc = 1'b0;
    #2 reset = 1'b1;
    tick();
    run_vec(tbl[5], "after rst");

`ifdef WB_IC_TIMEOUT_EN
    // hung UART: error after TMO REQ/WAIT cycles, later ack ignored
    start(32'hc000_0004, 32'h0, 1'b0);
    tick();
    m_stb = 1'b0;
    err_c = -1; ack_n = 0; cyc_at_err = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      s_ack = (err_c > 0 && t == err_c + 1) ? 3'b100 : 3'b000;
      if (o_m_err && err_c < 0) begin err_c = t; cyc_at_err = o_s_cyc; end
      if (o_m_ack) ack_n++;
      tick();
    end
    chk("tmo err cycle", err_c, 1 + TMO);
    chk("tmo cyc at err", 32'(cyc_at_err), 32'd0);
    chk("tmo late ack", ack_n, 0);
    m_cyc = 1'b0; s_ack = '0;
    tick();

    // cycle drop in the expiry cycle: abort wins, no error
    start(32'hc000_0004, 32'h0, 1'b0);
    tick();
    m_stb = 1'b0;
    n_bad = 0;
    for (int t = 1; t <= 8; t++) begin
      if (t == TMO) m_cyc = 1'b0;
      if (o_m_err || o_m_ack) n_bad++;
      tick();
    end
    chk("tmo abort wins", n_bad, 0);
    chk("tmo abort idle", 32'(o_m_stl), 32'd0);
`else
    // hung UART without timeout: waits indefinitely
    start(32'hc000_0004, 32'h0, 1'b0);
    tick();
    m_stb = 1'b0;
    n_bad = 0; n_low = 0;
    for (int t = 1; t <= 300; t++) begin
      if (o_m_err || o_m_ack) n_bad++;
      if (!o_s_cyc) n_low++;
      tick();
    end
    chk("hung no resp", n_bad, 0);
    chk("hung cyc held", n_low, 0);
    m_cyc = 1'b0;
    tick();
    chk("hung abort", {o_m_stl, o_s_cyc, o_m_err}, 32'd0);
`endif
    run_vec(tbl[3], "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
